// File: rtl/vc_test_sink_arbiter.sv
// vc_test_sink_arbiter
// Round-robin arbiter that shares one val/rdy test sink between p_num_reqs
// producers. It forwards {grant id, msg} and holds a grant while the sink
// applies back-pressure.
// Optional feature macro: VC_TEST_SINK_ARBITER_WATCHDOG_EN adds a sticky
// stall watchdog on out_val && !out_rdy. Without the macro, timeout is 0.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | free arbitration, round-robin from ptr_q; zero-latency grant
// ST_LOCKED | the sink stalled a granted message; selection fixed to gnt_q

module vc_test_sink_arbiter #(
  parameter int p_num_reqs = 4,
  parameter int p_msg_sz   = 8,
  parameter int p_timeout  = 256,
  localparam int c_id_sz   = $clog2(p_num_reqs)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [p_num_reqs-1:0]            in_val,
  output logic [p_num_reqs-1:0]            in_rdy,
  input  logic [p_num_reqs*p_msg_sz-1:0]   in_msg,
  output logic                             out_val,
  input  logic                             out_rdy,
  output logic [c_id_sz+p_msg_sz-1:0]      out_msg,
  output logic [31:0]                      xfer_count,
  output logic                             timeout
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [c_id_sz-1:0]   ptr_q, ptr_d;
  logic [c_id_sz-1:0]   gnt_q, gnt_d;
  logic [31:0]          xfer_count_q, xfer_count_d;

  logic [c_id_sz-1:0]   rr_gnt;
  logic                 rr_found;
  int                   scan_idx;
  logic [c_id_sz-1:0]   sel;
  logic [c_id_sz-1:0]   ptr_inc;
  logic                 out_val_c;
  logic                 xfer;

  // Round-robin scan: first valid requester starting at ptr_q, with wrap
  always_comb begin
    rr_gnt   = ptr_q;
    rr_found = 1'b0;
    scan_idx = 0;
    for (int i = 0; i < p_num_reqs; i++) begin
      scan_idx = int'(ptr_q) + i;
      if (scan_idx >= p_num_reqs) scan_idx = scan_idx - p_num_reqs;
      if (!rr_found && in_val[scan_idx]) begin
        rr_gnt   = c_id_sz'(scan_idx);
        rr_found = 1'b1;
      end
    end
  end

  // Output selection, handshake, and next-state logic
  always_comb begin
    sel       = (state_q == ST_LOCKED) ? gnt_q : rr_gnt;
    out_val_c = 1'b0;
    if (!reset) begin
      out_val_c = (state_q == ST_LOCKED) ? in_val[gnt_q] : (|in_val);
    end
    xfer    = out_val_c && out_rdy;
    ptr_inc = (sel == c_id_sz'(p_num_reqs - 1)) ? '0 : sel + 1'b1;

    in_rdy = '0;
    if (out_val_c) in_rdy[sel] = out_rdy;
    out_msg = {sel, in_msg[int'(sel)*p_msg_sz +: p_msg_sz]};

    state_d      = state_q;
    ptr_d        = ptr_q;
    gnt_d        = gnt_q;
    xfer_count_d = xfer_count_q;

    if (xfer) begin
      ptr_d        = ptr_inc;
      xfer_count_d = xfer_count_q + 32'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (out_val_c && !out_rdy) begin
          state_d = ST_LOCKED;
          gnt_d   = rr_gnt;
        end
      end
      ST_LOCKED: begin
        // Either the held message went out, or its producer dropped valid
        if (xfer || !in_val[gnt_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, pointer, grant, and transfer counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      gnt_q        <= '0;
      xfer_count_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gnt_q        <= gnt_d;
      xfer_count_q <= xfer_count_d;
    end
  end

  assign out_val    = out_val_c;
  assign xfer_count = xfer_count_q;

`ifdef VC_TEST_SINK_ARBITER_WATCHDOG_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        timeout_q, timeout_d;

  // Stall counter runs while the sink refuses a valid message; flag is sticky
  always_comb begin
    stall_cnt_d = '0;
    timeout_d   = timeout_q;
    if (out_val_c && !out_rdy) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
      if (stall_cnt_d >= 32'(p_timeout)) timeout_d = 1'b1;
    end
  end

  // Watchdog registers; the stalled grant id is reported once when the flag rises
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
`ifndef SYNTHESIS
      if (timeout_d && !timeout_q) begin
        $display("vc_test_sink_arbiter: watchdog timeout, stalled grant id %0d", sel);
      end
`endif
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_p_timeout;
  assign unused_p_timeout = (p_timeout != 0);
  assign timeout          = 1'b0;
`endif

endmodule
